// File: rtl/uart_packet_parser.sv
// Frames UART RX bytes as SYNC, LEN, payload, CHK and streams checked payload
// over valid/ready; malformed frames are dropped and reported with a reason code.
module uart_packet_parser #(
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         MAX_LEN        = 16,
  parameter int         TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  output logic [7:0] pkt_data,
  output logic       pkt_valid,
  input  logic       pkt_ready,
  output logic       pkt_last,
  output logic [7:0] pkt_len,
  output logic       err_valid,
  output logic [1:0] err_code
);

  localparam int             IW       = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int             TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]  TMAX     = TW'(TIMEOUT_CYCLES);
  localparam logic [7:0]     MAX_LEN8 = 8'(MAX_LEN);

  localparam logic [1:0] E_LEN = 2'd0;
  localparam logic [1:0] E_CHK = 2'd1;
  localparam logic [1:0] E_TMO = 2'd2;
  localparam logic [1:0] E_OVR = 2'd3;

  typedef enum logic [2:0] {S_IDLE, S_LEN, S_PAYLOAD, S_CHK, S_SEND} state_t;

  state_t        state;
  logic          rx_done_q;
  logic [7:0]    len_q;
  logic [7:0]    chk;
  logic [7:0]    idx;
  logic [7:0]    rd;
  logic [TW-1:0] tcnt;
  logic [7:0]    mem [2**IW];

  logic       byte_ev;
  logic       tmo;
  logic       counting;
  logic [7:0] rd_nx;

  // rx_done is a level; only its rising edge is a new byte
  assign byte_ev  = rx_done & ~rx_done_q;
  assign counting = (state == S_LEN) || (state == S_PAYLOAD) || (state == S_CHK);
  assign tmo      = counting && !byte_ev && (tcnt == TMAX);
  assign rd_nx    = rd + 8'd1;

  // Payload buffer carries no reset; contents are only read after being written
  always_ff @(posedge clk) begin
    if (!rst && state == S_PAYLOAD && byte_ev)
      mem[idx[IW-1:0]] <= rx_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      rx_done_q <= 1'b0;
      len_q     <= 8'd0;
      chk       <= 8'd0;
      idx       <= 8'd0;
      rd        <= 8'd0;
      tcnt      <= '0;
      pkt_valid <= 1'b0;
      pkt_data  <= 8'd0;
      pkt_last  <= 1'b0;
      pkt_len   <= 8'd0;
      err_valid <= 1'b0;
      err_code  <= 2'd0;
    end else begin
      rx_done_q <= rx_done;
      err_valid <= 1'b0;

      if (byte_ev || !counting) tcnt <= '0;
      else if (tcnt != TMAX)    tcnt <= tcnt + TW'(1);
      else                      tcnt <= '0;

      case (state)
        S_IDLE: begin
          if (byte_ev && rx_data == SYNC_BYTE) state <= S_LEN;
        end
        S_LEN: begin
          if (byte_ev) begin
            if (rx_data == 8'd0 || rx_data > MAX_LEN8) begin
              err_valid <= 1'b1;
              err_code  <= E_LEN;
              state     <= S_IDLE;
            end else begin
              len_q   <= rx_data;
              pkt_len <= rx_data;
              chk     <= rx_data;
              idx     <= 8'd0;
              state   <= S_PAYLOAD;
            end
          end
        end
        S_PAYLOAD: begin
          if (byte_ev) begin
            chk <= chk ^ rx_data;
            idx <= idx + 8'd1;
            if (idx == len_q - 8'd1) state <= S_CHK;
          end
        end
        S_CHK: begin
          if (byte_ev) begin
            if (rx_data == chk) begin
              // First payload byte is presented on the same edge the CHK is taken
              rd        <= 8'd0;
              pkt_valid <= 1'b1;
              pkt_data  <= mem[{IW{1'b0}}];
              pkt_last  <= (len_q == 8'd1);
              state     <= S_SEND;
            end else begin
              err_valid <= 1'b1;
              err_code  <= E_CHK;
              state     <= S_IDLE;
            end
          end
        end
        S_SEND: begin
          if (byte_ev) begin
            err_valid <= 1'b1;
            err_code  <= E_OVR;
          end
          if (pkt_ready) begin
            if (pkt_last) begin
              pkt_valid <= 1'b0;
              pkt_last  <= 1'b0;
              state     <= S_IDLE;
            end else begin
              rd       <= rd_nx;
              pkt_data <= mem[rd_nx[IW-1:0]];
              pkt_last <= (rd_nx == len_q - 8'd1);
            end
          end
        end
        default: state <= S_IDLE;
      endcase

      // A byte on the expiry cycle wins, so tmo already excludes byte_ev
      if (tmo) begin
        err_valid <= 1'b1;
        err_code  <= E_TMO;
        state     <= S_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_uart_packet_parser.sv
// Randomized plus directed bench for uart_packet_parser; expected packets and
// error codes are queued at stimulus time and checked by an output monitor.
module tb_uart_packet_parser;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_done = 1'b0;
  logic [7:0] pkt_data;
  logic       pkt_valid;
  logic       pkt_ready = 1'b1;
  logic       pkt_last;
  logic [7:0] pkt_len;
  logic       err_valid;
  logic [1:0] err_code;

  uart_packet_parser #(
    .SYNC_BYTE     (8'hA5),
    .MAX_LEN       (16),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_done  (rx_done),
    .pkt_data (pkt_data),
    .pkt_valid(pkt_valid),
    .pkt_ready(pkt_ready),
    .pkt_last (pkt_last),
    .pkt_len  (pkt_len),
    .err_valid(err_valid),
    .err_code (err_code)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       l;
    logic [7:0] len;
  } exp_t;

  exp_t       exp_pkt[$];
  logic [1:0] exp_err[$];
  int         xfer_cyc[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         ready_mode = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (ready_mode == 0)      pkt_ready = 1'b1;
    else if (ready_mode == 1) pkt_ready = 1'($urandom_range(0, 1));
  end

  // Output monitor / scoreboard
  initial begin
    logic       stall_prev = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic       prev_last = 1'b0;
    exp_t       e;
    logic [1:0] c;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_prev = 1'b0;
      end else begin
        if (pkt_valid && stall_prev) begin
          check("stall_data_hold", pkt_data, prev_data);
          check("stall_last_hold", pkt_last, prev_last);
        end
        if (pkt_valid && pkt_ready) begin
          xfer_cyc.push_back(cyc);
          if (exp_pkt.size() == 0) begin
            check("unexpected_pkt_byte", pkt_data, 32'hFFFF_FFFF);
          end else begin
            e = exp_pkt.pop_front();
            check("pkt_data", pkt_data, e.d);
            check("pkt_last", pkt_last, e.l);
            check("pkt_len", pkt_len, e.len);
          end
        end
        if (err_valid) begin
          if (exp_err.size() == 0) begin
            check("unexpected_err", err_code, 32'hFFFF_FFFF);
          end else begin
            c = exp_err.pop_front();
            check("err_code", err_code, c);
          end
        end
        stall_prev = pkt_valid && !pkt_ready;
        prev_data  = pkt_data;
        prev_last  = pkt_last;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  // Entered and left at posedge+1; the byte is consumed on the first edge
  task automatic send_byte(input logic [7:0] b, input int hold = 1);
    rx_data = b;
    rx_done = 1'b1;
    repeat (hold) @(posedge clk);
    #1 rx_done = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic push_good(input logic [7:0] pl[$]);
    exp_t e;
    foreach (pl[i]) begin
      e.d = pl[i];
      e.l = (i == pl.size() - 1);
      e.len = 8'(pl.size());
      exp_pkt.push_back(e);
    end
  endtask

  function automatic logic [7:0] xsum(input logic [7:0] pl[$]);
    logic [7:0] s = 8'(pl.size());
    foreach (pl[i]) s ^= pl[i];
    return s;
  endfunction

  task automatic send_frame(input logic [7:0] pl[$], input logic [7:0] chk_b);
    send_byte(8'hA5);
    send_byte(8'(pl.size()));
    foreach (pl[i]) send_byte(pl[i]);
    send_byte(chk_b);
  endtask

  task automatic send_good(input logic [7:0] pl[$]);
    push_good(pl);
    send_frame(pl, xsum(pl));
  endtask

  function automatic void rand_payload(input int n, output logic [7:0] pl[$]);
    pl = {};
    for (int i = 0; i < n; i++) pl.push_back(8'($urandom));
  endfunction

  task automatic wait_drain();
    int n = 0;
    while ((exp_pkt.size() != 0 || pkt_valid) && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_within_bound", (n < 500), 1);
  endtask

  initial begin
    logic [7:0] pl[$];
    logic [7:0] b;
    int         base;
    int         n;

    repeat (3) @(posedge clk);
    #1;
    check("rst_pkt_valid", pkt_valid, 0);
    check("rst_pkt_last", pkt_last, 0);
    check("rst_pkt_data", pkt_data, 0);
    check("rst_pkt_len", pkt_len, 0);
    check("rst_err_valid", err_valid, 0);
    check("rst_err_code", err_code, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Garbage before sync, then a 3-byte packet with first-byte latency check
    pl = '{8'h11, 8'h22, 8'h33};
    push_good(pl);
    send_byte(8'h00);
    send_byte(8'h7E);
    send_byte(8'hA5);
    send_byte(8'h03);
    foreach (pl[i]) send_byte(pl[i]);
    base = xfer_cyc.size();
    rx_data = 8'h03;
    rx_done = 1'b1;
    @(posedge clk);
    #1;
    check("chk_edge_valid", pkt_valid, 1);
    check("chk_edge_data", pkt_data, 8'h11);
    rx_done = 1'b0;
    wait_drain();
    check("xfer_count", xfer_cyc.size() - base, 3);
    if (xfer_cyc.size() >= base + 3) begin
      check("consec_1", xfer_cyc[base+1] - xfer_cyc[base], 1);
      check("consec_2", xfer_cyc[base+2] - xfer_cyc[base+1], 1);
    end

    // Bad checksum, then a good packet
    exp_err.push_back(2'd1);
    send_frame('{8'hAA, 8'h55}, 8'h00);
    check("badchk_no_valid", pkt_valid, 0);
    send_good('{8'h01, 8'h02});
    wait_drain();

    // Length bounds
    exp_err.push_back(2'd0);
    send_byte(8'hA5);
    send_byte(8'h00);
    exp_err.push_back(2'd0);
    send_byte(8'hA5);
    send_byte(8'h11);
    rand_payload(16, pl);
    send_good(pl);
    wait_drain();

    // Backpressure: stalled 10 cycles, then alternating ready
    ready_mode = 2;
    pkt_ready = 1'b0;
    rand_payload(4, pl);
    send_good(pl);
    repeat (10) @(posedge clk);
    #1;
    n = 0;
    while ((exp_pkt.size() != 0 || pkt_valid) && n < 40) begin
      pkt_ready = ~n[0];
      @(posedge clk);
      #1;
      n++;
    end
    check("bp_drained", (exp_pkt.size() == 0) && !pkt_valid, 1);
    ready_mode = 0;
    pkt_ready = 1'b1;

    // Timeout: error exactly TIMEOUT_CYCLES+1 cycles after the last byte edge
    exp_err.push_back(2'd2);
    send_byte(8'hA5);
    send_byte(8'h02);
    rx_data = 8'hAA;
    rx_done = 1'b1;
    @(posedge clk);
    #1;
    rx_done = 1'b0;
    n = 0;
    for (int i = 1; i <= 300; i++) begin
      @(posedge clk);
      #1;
      if (err_valid) begin
        n = i;
        break;
      end
    end
    check("timeout_latency", n, 101);
    send_good('{8'h5A, 8'hC3, 8'h3C});
    wait_drain();

    // Long rx_done level on SYNC counts once
    rand_payload(2, pl);
    push_good(pl);
    send_byte(8'hA5, 50);
    send_byte(8'h02);
    foreach (pl[i]) send_byte(pl[i]);
    send_byte(xsum(pl));
    wait_drain();

    // Overrun while stalled in SEND
    ready_mode = 2;
    pkt_ready = 1'b0;
    rand_payload(3, pl);
    send_good(pl);
    repeat (2) @(posedge clk);
    #1;
    exp_err.push_back(2'd3);
    send_byte(8'h5A);
    check("overrun_still_valid", pkt_valid, 1);
    ready_mode = 0;
    wait_drain();

    // Reset mid-payload
    send_byte(8'hA5);
    send_byte(8'h04);
    send_byte(8'h11);
    send_byte(8'h22);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_pkt_valid", pkt_valid, 0);
    check("midrst_pkt_last", pkt_last, 0);
    check("midrst_pkt_data", pkt_data, 0);
    check("midrst_pkt_len", pkt_len, 0);
    check("midrst_err_valid", err_valid, 0);
    check("midrst_err_code", err_code, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_no_err", err_valid, 0);
    send_good('{8'h77});
    wait_drain();

    // Randomized frame mix with random backpressure
    ready_mode = 1;
    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 3))
        0: begin
          rand_payload($urandom_range(1, 16), pl);
          send_good(pl);
          wait_drain();
        end
        1: begin
          exp_err.push_back(2'd0);
          send_byte(8'hA5);
          send_byte(($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(17, 255)));
        end
        2: begin
          rand_payload($urandom_range(1, 16), pl);
          exp_err.push_back(2'd1);
          send_frame(pl, xsum(pl) ^ 8'($urandom_range(1, 255)));
        end
        default: begin
          b = 8'($urandom);
          if (b == 8'hA5) b = 8'h5A;
          send_byte(b);
        end
      endcase
    end
    ready_mode = 0;
    repeat (5) @(posedge clk);
    #1;
    check("exp_pkt_empty", exp_pkt.size(), 0);
    check("exp_err_empty", exp_err.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
